// File: rtl/counter_pkg.sv
// Shared definitions for the up_counter / down_counter pair:
// FSM state encoding and the default counter width.
package counter_pkg;

  localparam int CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter / interval timer with a one-cycle terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN to auto-reload from the last loaded value instead of stopping.
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

`ifdef DOWN_COUNTER_RELOAD_EN
  localparam bit RELOAD_EN = 1'b1;
`else
  localparam bit RELOAD_EN = 1'b0;
`endif

  cnt_state_t       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_count  <= load_val;
        r_reload <= load_val;
        r_state  <= (load_val != '0) ? RUN : EXPIRED;
      end else begin
        case (r_state)
          RUN: begin
            if (en) begin
              if (r_count > WIDTH'(1)) begin
                r_count <= r_count - WIDTH'(1);
              end else if (r_count == WIDTH'(1)) begin
                r_count <= '0;
                r_tc    <= 1'b1;
                r_state <= RELOAD_EN ? RUN : EXPIRED;
              end else if (RELOAD_EN && (r_reload != '0)) begin
                // count already 0: start the next period
                r_count <= r_reload;
              end else begin
                r_state <= EXPIRED;
              end
            end
          end
          EXPIRED: r_count <= '0;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);
  assign tc    = r_tc;
  assign busy  = (r_state == RUN);

endmodule

// File: tb/tb_down_counter.sv
// Directed, table-driven bench for down_counter; reload expectations follow
// DOWN_COUNTER_RELOAD_EN when the bench is built with it.
module tb_down_counter;

`ifdef DOWN_COUNTER_RELOAD_EN
  localparam logic RELOAD = 1'b1;
`else
  localparam logic RELOAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count;
  logic       zero;
  logic       tc;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  down_counter #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .zero     (zero),
    .tc       (tc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic       en;
    logic [7:0] val;
    logic [7:0] c;
    logic       z;
    logic       tc;
    logic       busy;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] c, input logic z,
                         input logic t, input logic b);
    chk({name, ".count"}, {24'd0, count}, {24'd0, c});
    chk({name, ".zero"}, {31'd0, zero}, {31'd0, z});
    chk({name, ".tc"}, {31'd0, tc}, {31'd0, t});
    chk({name, ".busy"}, {31'd0, busy}, {31'd0, b});
  endtask

  task automatic step(input logic ld, input logic e, input logic [7:0] v);
    @(negedge clk);
    load     = ld;
    en       = e;
    load_val = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // idle, basic countdown, enable gaps, load collision, load 0, tc width
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, RELOAD};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, RELOAD};
    vecs[6]  = '{1'b1, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h04, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, RELOAD};
    vecs[15] = '{1'b1, 1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 8'hA0, 8'hA0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 8'h00, 8'h9F, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, RELOAD};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, RELOAD};

    // reset held with random stimulus
    #1;
    chk_all("reset0", 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)));
      chk_all($sformatf("reset_hold%0d", i), 8'h00, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    load = 1'b0;
    en   = 1'b0;
    rst  = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].load, vecs[i].en, vecs[i].val);
      chk_all($sformatf("vec%0d", i), vecs[i].c, vecs[i].z, vecs[i].tc, vecs[i].busy);
    end

    // periodic behaviour (or stop) after loading 2 with en held
    step(1'b1, 1'b1, 8'h02);
    chk_all("per_load", 8'h02, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] ec;
      logic       et;
      logic       eb;
      if (RELOAD) begin
        ec = 8'(2 - ((i + 1) % 3));
        et = (ec == 8'h00);
        eb = 1'b1;
      end else begin
        ec = (i == 0) ? 8'h01 : 8'h00;
        et = (i == 1);
        eb = (i == 0);
      end
      step(1'b0, 1'b1, 8'h00);
      chk_all($sformatf("per%0d", i), ec, (ec == 8'h00), et, eb);
    end

    // asynchronous reset in the middle of a long count
    step(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    chk_all("pre_async", 8'hF5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    chk_all("post_rst0", 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    chk_all("post_rst1", 8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
